// File: rtl/led_fade_scheduler.sv
// led_fade_scheduler: 8-channel PWM LED driver whose duties fade one LSB per step toward written targets.
// A shared counter sets the PWM period; every STEP_DIV periods an 8-cycle pass nudges each channel.
module led_fade_scheduler #(
    parameter int CTR_LEN  = 8,
    parameter int STEP_DIV = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [2:0]         wr_chan,
    input  logic [CTR_LEN-1:0] wr_target,
    output logic [7:0]         led,
    output logic               busy,
    output logic               period_tick
);
    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CTR_LEN-1:0] MAX = '1;
    localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);

    typedef enum logic {IDLE, STEP} state_t;

    state_t             state_q, state_d;
    logic [CTR_LEN-1:0] ctr_q;
    logic [DW-1:0]      div_q, div_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         led_q;
    logic [CTR_LEN-1:0] target_q [8];
    logic [CTR_LEN-1:0] duty_q   [8];
    logic [CTR_LEN-1:0] act_q    [8];
    logic [CTR_LEN-1:0] duty_cur, tgt_cur, duty_d;
    logic               wrap, step_req;

    assign wrap        = ctr_q == MAX;
    assign step_req    = wrap && div_q == DIV_LAST;
    assign period_tick = wrap;
    assign wr_ready    = state_q == IDLE;
    assign led         = led_q;
    assign duty_cur    = duty_q[idx_q];
    assign tgt_cur     = target_q[idx_q];

    always_comb begin
        state_d = state_q;
        idx_d   = 3'd0;
        div_d   = wrap ? (step_req ? '0 : div_q + 1'b1) : div_q;
        duty_d  = (duty_cur < tgt_cur) ? duty_cur + 1'b1 :
                  (duty_cur > tgt_cur) ? duty_cur - 1'b1 : duty_cur;
        if (state_q == IDLE)
            state_d = step_req ? STEP : IDLE;
        else begin
            state_d = (idx_q == 3'd7) ? IDLE : STEP;
            idx_d   = idx_q + 3'd1;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < 8; i++)
            busy = busy | (duty_q[i] != target_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            led_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                target_q[i] <= '0;
                duty_q[i]   <= '0;
                act_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_q + 1'b1;
            div_q   <= div_d;
            idx_q   <= idx_d;
            if (wr_valid && wr_ready)
                target_q[wr_chan] <= wr_target;
            if (state_q == STEP)
                duty_q[idx_q] <= duty_d;
            // compare values only change at the wrap so a period is never split
            for (int i = 0; i < 8; i++) begin
                if (wrap)
                    act_q[i] <= duty_q[i];
                led_q[i] <= act_q[i] > ctr_q;
            end
        end
    end
endmodule
